// File: rtl/status_flags_if.sv
// Bundle between the ALU/control unit and the status-flag register.
// The master drives ALU results and stack commands; the slave returns live flags and stack status.
interface status_flags_if #(
   parameter int DATA_WIDTH  = 11,
   parameter int STACK_DEPTH = 4
);
   localparam int DW = $clog2(STACK_DEPTH + 1);

   logic [DATA_WIDTH-1:0] flags_in;
   logic                  flags_carry_in;
   logic                  flags_ovf_in;
   logic                  flags_wr;
   logic                  flags_arith;
   logic                  flags_push;
   logic                  flags_pop;
   logic                  flag_Z;
   logic                  flag_N;
   logic                  flag_C;
   logic                  flag_V;
   logic                  flags_stack_full;
   logic                  flags_stack_empty;
   logic                  flags_stack_err;
   logic [DW-1:0]         flags_depth;

   modport master (
      output flags_in, flags_carry_in, flags_ovf_in, flags_wr, flags_arith,
             flags_push, flags_pop,
      input  flag_Z, flag_N, flag_C, flag_V, flags_stack_full, flags_stack_empty,
             flags_stack_err, flags_depth
   );

   modport slave (
      input  flags_in, flags_carry_in, flags_ovf_in, flags_wr, flags_arith,
             flags_push, flags_pop,
      output flag_Z, flag_N, flag_C, flag_V, flags_stack_full, flags_stack_empty,
             flags_stack_err, flags_depth
   );
endinterface

// File: rtl/status_flags.sv
// Z/N/C/V status-flag register with a LIFO save stack for interrupt/subroutine entry.
// All state is registered; reset is synchronous and active-low.
module status_flags #(
   parameter int DATA_WIDTH  = 11,
   parameter int STACK_DEPTH = 4
) (
   input logic           clock,
   input logic           flags_reset_n,
   status_flags_if.slave bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic          z_q, n_q, c_q, v_q, err_q;
   logic [DW-1:0] depth_q;
   logic [3:0]    stack_q [STACK_DEPTH];

   logic          z_next, n_next;
   logic          full, empty;
   logic          push_ok, pop_ok, stack_fault;
   logic [AW-1:0] wr_idx, rd_idx;

   assign z_next = (bus.flags_in == '0);
   assign n_next = bus.flags_in[DATA_WIDTH-1];

   assign full  = (depth_q == DW'(STACK_DEPTH));
   assign empty = (depth_q == '0);

   // Simultaneous push and pop cancel each other and are not an error.
   assign push_ok     = bus.flags_push & ~bus.flags_pop & ~full;
   assign pop_ok      = bus.flags_pop & ~bus.flags_push & ~empty;
   assign stack_fault = (bus.flags_push & ~bus.flags_pop & full) |
                        (bus.flags_pop & ~bus.flags_push & empty);

   assign wr_idx = depth_q[AW-1:0];
   assign rd_idx = AW'(depth_q - DW'(1));

   // Entry contents need no reset; a discarded stack is simply depth 0.
   always_ff @(posedge clock) begin
      if (flags_reset_n && push_ok) begin
         stack_q[wr_idx] <= {z_q, n_q, c_q, v_q};
      end
   end

   always_ff @(posedge clock) begin
      if (!flags_reset_n) begin
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         err_q   <= 1'b0;
         depth_q <= '0;
      end else begin
         if (pop_ok) begin
            {z_q, n_q, c_q, v_q} <= stack_q[rd_idx];
         end else if (bus.flags_wr) begin
            z_q <= z_next;
            n_q <= n_next;
            if (bus.flags_arith) begin
               c_q <= bus.flags_carry_in;
               v_q <= bus.flags_ovf_in;
            end
         end

         if (push_ok) begin
            depth_q <= depth_q + DW'(1);
         end else if (pop_ok) begin
            depth_q <= depth_q - DW'(1);
         end

         if (stack_fault) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.flag_Z            = z_q;
   assign bus.flag_N            = n_q;
   assign bus.flag_C            = c_q;
   assign bus.flag_V            = v_q;
   assign bus.flags_stack_full  = full;
   assign bus.flags_stack_empty = empty;
   assign bus.flags_stack_err   = err_q;
   assign bus.flags_depth       = depth_q;
endmodule

// File: tb/tb_status_flags.sv
// Bench for status_flags: directed scenarios then random traffic, checked against a queue-based model.
module tb_status_flags;
   localparam int DATA_WIDTH  = 11;
   localparam int STACK_DEPTH = 4;
   localparam int DW          = $clog2(STACK_DEPTH + 1);

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   status_flags_if #(.DATA_WIDTH(DATA_WIDTH), .STACK_DEPTH(STACK_DEPTH)) bus ();

   status_flags #(.DATA_WIDTH(DATA_WIDTH), .STACK_DEPTH(STACK_DEPTH)) dut (
      .clock         (clock),
      .flags_reset_n (rst_n),
      .bus           (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: live flags plus a queue of saved {Z,N,C,V} words.
   logic       m_z, m_n, m_c, m_v, m_err;
   logic [3:0] m_stack [$];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, " Z"}, 8'(bus.flag_Z), 8'(m_z));
      chk({ctx, " N"}, 8'(bus.flag_N), 8'(m_n));
      chk({ctx, " C"}, 8'(bus.flag_C), 8'(m_c));
      chk({ctx, " V"}, 8'(bus.flag_V), 8'(m_v));
      chk({ctx, " depth"}, 8'(bus.flags_depth), 8'(m_stack.size()));
      chk({ctx, " full"}, 8'(bus.flags_stack_full), 8'(m_stack.size() == STACK_DEPTH));
      chk({ctx, " empty"}, 8'(bus.flags_stack_empty), 8'(m_stack.size() == 0));
      chk({ctx, " err"}, 8'(bus.flags_stack_err), 8'(m_err));
   endtask

   task automatic model_edge(input logic rst, input logic wr, input logic arith,
                             input logic push, input logic pop,
                             input logic [DATA_WIDTH-1:0] din, input logic cy, input logic ov);
      logic [3:0] saved;
      saved = {m_z, m_n, m_c, m_v};
      if (!rst) begin
         {m_z, m_n, m_c, m_v, m_err} = '0;
         m_stack.delete();
         return;
      end
      if (wr) begin
         m_z = (din == 0);
         m_n = din[DATA_WIDTH-1];
         if (arith) begin
            m_c = cy;
            m_v = ov;
         end
      end
      if (push && !pop) begin
         if (m_stack.size() == STACK_DEPTH) m_err = 1'b1;
         else m_stack.push_back(saved);
      end else if (pop && !push) begin
         if (m_stack.size() == 0) m_err = 1'b1;
         else {m_z, m_n, m_c, m_v} = m_stack.pop_back();
      end
   endtask

   task automatic step(input string ctx, input logic rst, input logic wr, input logic arith,
                       input logic push, input logic pop,
                       input logic [DATA_WIDTH-1:0] din, input logic cy, input logic ov);
      @(negedge clock);
      rst_n              = rst;
      bus.flags_wr       = wr;
      bus.flags_arith    = arith;
      bus.flags_push     = push;
      bus.flags_pop      = pop;
      bus.flags_in       = din;
      bus.flags_carry_in = cy;
      bus.flags_ovf_in   = ov;
      @(posedge clock);
      model_edge(rst, wr, arith, push, pop, din, cy, ov);
      #1;
      check_all(ctx);
   endtask

   initial begin
      bus.flags_wr = 0; bus.flags_arith = 0; bus.flags_push = 0; bus.flags_pop = 0;
      bus.flags_in = '0; bus.flags_carry_in = 0; bus.flags_ovf_in = 0;
      {m_z, m_n, m_c, m_v, m_err} = '0;

      // Reset with a write that must be ignored
      step("reset", 0, 1, 1, 0, 0, 11'h400, 1, 1);
      chk("reset Z lit", 8'(bus.flag_Z), 8'd0);
      chk("reset empty lit", 8'(bus.flags_stack_empty), 8'd1);

      // Z/N only
      step("zn_wr", 1, 1, 0, 0, 0, 11'b10000100000, 1, 1);
      chk("zn_wr N lit", 8'(bus.flag_N), 8'd1);
      chk("zn_wr C lit", 8'(bus.flag_C), 8'd0);
      step("zn_hold", 1, 0, 0, 0, 0, 11'h000, 0, 0);
      step("zn_zero", 1, 1, 0, 0, 0, 11'h000, 0, 0);
      chk("zn_zero Z lit", 8'(bus.flag_Z), 8'd1);

      // Arithmetic update
      step("arith", 1, 1, 1, 0, 0, 11'h7FF, 1, 1);
      chk("arith ZNCV lit", 8'({bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V}), 8'b0111);

      // Push with write, then pop restores the old flags
      step("push_wr", 1, 1, 1, 1, 0, 11'h000, 0, 0);
      chk("push_wr ZNCV lit", 8'({bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V}), 8'b1000);
      step("pop", 1, 0, 0, 0, 1, 11'h000, 0, 0);
      chk("pop ZNCV lit", 8'({bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V}), 8'b0111);

      // Push and pop together: only the write is honoured
      step("push_pop", 1, 1, 1, 1, 1, 11'h001, 1, 0);

      // Five pushes of distinct states: overflow on the fifth
      step("fill1", 1, 1, 1, 1, 0, 11'h000, 0, 1);
      step("fill2", 1, 1, 1, 1, 0, 11'h400, 1, 0);
      step("fill3", 1, 1, 1, 1, 0, 11'h002, 0, 0);
      step("fill4", 1, 1, 1, 1, 0, 11'h7FF, 1, 1);
      chk("fill4 full lit", 8'(bus.flags_stack_full), 8'd1);
      step("fill5", 1, 1, 0, 1, 0, 11'h000, 0, 0);
      chk("fill5 err lit", 8'(bus.flags_stack_err), 8'd1);
      chk("fill5 depth lit", 8'(bus.flags_depth), 8'd4);

      // Drain in LIFO order, then underflow
      for (int i = 0; i < 4; i++) step("drain", 1, 1, 1, 0, 1, 11'h3FF, 1, 1);
      step("underflow", 1, 0, 0, 0, 1, 11'h000, 0, 0);

      // Back-to-back push then pop returns the just-pushed value
      step("b2b_push", 1, 1, 1, 1, 0, 11'h555, 0, 1);
      step("b2b_pop", 1, 0, 0, 0, 1, 11'h000, 0, 0);

      // Short reset pulse between edges has no effect
      @(negedge clock);
      rst_n = 0;
      #2;
      rst_n = 1;
      @(posedge clock);
      #1;
      check_all("async_pulse");

      // Mid-operation reset with push pending
      step("pre3_1", 1, 1, 1, 1, 0, 11'h100, 1, 0);
      step("pre3_2", 1, 1, 1, 1, 0, 11'h000, 0, 1);
      step("pre3_3", 1, 1, 1, 1, 0, 11'h401, 1, 1);
      chk("pre3 depth lit", 8'(bus.flags_depth), 8'd3);
      step("mid_rst", 0, 0, 0, 1, 0, 11'h000, 0, 0);
      chk("mid_rst depth lit", 8'(bus.flags_depth), 8'd0);
      chk("mid_rst err lit", 8'(bus.flags_stack_err), 8'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic r_rst, r_push, r_pop;
         logic [DATA_WIDTH-1:0] r_din;
         r_rst  = ($urandom_range(0, 60) != 0);
         r_push = ($urandom_range(0, 2) == 0);
         r_pop  = ($urandom_range(0, 2) == 0);
         r_din  = ($urandom_range(0, 3) == 0) ? '0 : DATA_WIDTH'($urandom);
         step("rand", r_rst, 1'($urandom), 1'($urandom), r_push, r_pop, r_din,
              1'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
